// File: rtl/cv32e40p_apu_int_responder.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_int_responder
//
// Purpose:
//   Slave end of the core's APU request/grant/rvalid interface, used in place
//   of the FP wrapper to offload integer work. Ops 0..6 (ADD, SUB, AND, OR,
//   XOR, MIN, MAX) are computed at grant time. They then pass through a
//   PIPE_LAT-deep register chain. Op 7 (MULU) runs on an iterative shift-add
//   multiplier that takes 32 cycles. Results come back strictly in grant
//   order, with one rvalid pulse per granted request.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   apu_req_i      request valid
//   apu_gnt_o      grant (combinational); a transfer occurs on req & gnt
//   apu_operands_i operands: [0]=A, [1]=B, remaining entries ignored
//   apu_op_i       opcode; only [2:0] are decoded
//   apu_flags_i    ignored; present for interface compatibility
//   apu_rvalid_o   single-cycle result pulse, no backpressure
//   apu_rdata_o    result, meaningful only while apu_rvalid_o is high
//   apu_rflags_o   [0]=zero, [1]=carry/borrow, [2]=signed overflow, rest 0
//   busy_o         a pipe stage is valid or the multiplier is not idle
//
// Configuration:
//   CV32E40P_APU_INT_RESPONDER_SVA_EN  compiles the inline protocol assertions.
//                                      The functional logic does not change.
// -----------------------------------------------------------------------------
module cv32e40p_apu_int_responder #(
  parameter int unsigned PIPE_LAT = 1,  // legal 1..4
  parameter int unsigned NARGS    = 3,
  parameter int unsigned WOP      = 6,
  parameter int unsigned NDSFLAGS = 15,
  parameter int unsigned NUSFLAGS = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                apu_req_i,
  output logic                apu_gnt_o,
  input  logic [31:0]         apu_operands_i [NARGS],
  input  logic [WOP-1:0]      apu_op_i,
  input  logic [NDSFLAGS-1:0] apu_flags_i,
  output logic                apu_rvalid_o,
  output logic [31:0]         apu_rdata_o,
  output logic [NUSFLAGS-1:0] apu_rflags_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MIN  = 3'd5,
    OP_MAX  = 3'd6,
    OP_MULU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int unsigned LAST = PIPE_LAT - 1;

  // ---------------------------------------------------------------------------
  // Unused inputs. They are folded into one sink so the intent is explicit.
  // ---------------------------------------------------------------------------
  logic        unused_inputs;
  logic [31:0] unused_ops;

  always_comb begin
    unused_ops = '0;
    for (int i = 0; i < int'(NARGS); i++) unused_ops ^= apu_operands_i[i];
  end

  assign unused_inputs = ^{apu_flags_i, apu_op_i, unused_ops};

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  op_e         op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        is_mul;

  assign op     = op_e'(apu_op_i[2:0]);
  assign opa    = apu_operands_i[0];
  assign opb    = apu_operands_i[1];
  assign is_mul = (op == OP_MULU);

  // ---------------------------------------------------------------------------
  // Single-cycle ALU for the pipelined ops. Evaluated on the request itself.
  // ---------------------------------------------------------------------------
  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] alu_res;
  logic        alu_carry;
  logic        alu_ovf;
  logic [2:0]  alu_flags;

  // NOTE: every combinational output gets a default before the case. A missing
  // default on any path would infer a latch.
  always_comb begin
    sum       = {1'b0, opa} + {1'b0, opb};
    // Bit 32 of a zero-extended subtract is set exactly when A < B unsigned.
    diff      = {1'b0, opa} - {1'b0, opb};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res   = sum[31:0];
        alu_carry = sum[32];
        alu_ovf   = (opa[31] == opb[31]) && (alu_res[31] != opa[31]);
      end
      OP_SUB: begin
        alu_res   = diff[31:0];
        alu_carry = diff[32];
        alu_ovf   = (opa[31] != opb[31]) && (alu_res[31] != opa[31]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_MIN:  alu_res = ($signed(opa) < $signed(opb)) ? opa : opb;
      OP_MAX:  alu_res = ($signed(opa) < $signed(opb)) ? opb : opa;
      OP_MULU: alu_res = '0;  // handled by the iterative multiplier
      default: alu_res = '0;
    endcase
    alu_flags = {alu_ovf, alu_carry, (alu_res == 32'd0)};
  end

  // ---------------------------------------------------------------------------
  // Pipeline for ops 0..6. Stage 0 is loaded at grant, and the last stage
  // drives the response. Latency is therefore exactly PIPE_LAT cycles.
  // ---------------------------------------------------------------------------
  logic [PIPE_LAT-1:0] pipe_vld;
  logic [31:0]         pipe_data  [PIPE_LAT];
  logic [2:0]          pipe_flags [PIPE_LAT];
  logic                pipe_empty;
  logic                xfer;

  state_e      state;
  state_e      state_d;
  logic [31:0] mul_a;
  logic [31:0] mul_a_d;
  logic [31:0] mul_b;
  logic [31:0] mul_b_d;
  logic [31:0] acc;
  logic [31:0] acc_d;
  logic [4:0]  cnt;
  logic [4:0]  cnt_d;

  assign pipe_empty = ~|pipe_vld;

  // MULU is granted only from IDLE with an empty pipe, so its response cannot
  // overtake or collide with a pipelined result. A pipelined op granted in
  // RESP lands at least one cycle after the MULU pulse.
  assign apu_gnt_o = apu_req_i
                   & ((state == S_IDLE) | (state == S_RESP))
                   & (~is_mul | ((state == S_IDLE) & pipe_empty));
  assign xfer      = apu_req_i & apu_gnt_o;

  // NOTE: the data registers are reset as well as the valids, although the
  // valids alone would gate them. Resetting them keeps apu_rdata_o and
  // apu_rflags_o at zero out of reset instead of X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        pipe_data[i]  <= '0;
        pipe_flags[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Each stage then
      // reads its predecessor's old value, and the chain shifts by exactly one.
      pipe_vld[0]   <= xfer & ~is_mul;
      pipe_data[0]  <= alu_res;
      pipe_flags[0] <= alu_flags;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_data[i]  <= pipe_data[i-1];
        pipe_flags[i] <= pipe_flags[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Iterative multiplier FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      mul_a <= mul_a_d;
      mul_b <= mul_b_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Iterative multiplier FSM: next state. Each MUL cycle consumes one bit of B.
  // With cnt running 31..0, a grant at t puts the response in cycle t+33.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    mul_a_d = mul_a;
    mul_b_d = mul_b;
    acc_d   = acc;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        if (xfer && is_mul) begin
          mul_a_d = opa;
          mul_b_d = opb;
          acc_d   = '0;
          cnt_d   = 5'd31;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (mul_b[0]) acc_d = acc + mul_a;
        mul_a_d = mul_a << 1;
        mul_b_d = mul_b >> 1;
        if (cnt == 5'd0) state_d = S_RESP;
        else             cnt_d   = cnt - 5'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response mux. By construction, only one of the two sources is ever active.
  // ---------------------------------------------------------------------------
  logic resp_vld;

  assign resp_vld     = (state == S_RESP);
  assign apu_rvalid_o = pipe_vld[LAST] | resp_vld;
  assign apu_rdata_o  = resp_vld ? acc : pipe_data[LAST];
  assign apu_rflags_o = resp_vld ? NUSFLAGS'({2'b00, (acc == 32'd0)})
                                 : NUSFLAGS'(pipe_flags[LAST]);
  assign busy_o       = (|pipe_vld) | (state != S_IDLE);

`ifdef CV32E40P_APU_INT_RESPONDER_SVA_EN
  // Grants accepted minus responses returned.
  int          outstanding;
  logic [63:0] ops_ab;

  assign ops_ab = {opb, opa};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) outstanding <= 0;
    else       outstanding <= outstanding + int'(xfer) - int'(apu_rvalid_o);
  end

  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (apu_req_i && !apu_gnt_o) |=> (apu_req_i && $stable(apu_op_i) && $stable(ops_ab)));

  a_one_source : assert property (@(posedge clk_i) disable iff (rst_i)
    !(pipe_vld[LAST] && resp_vld));

  a_outstanding : assert property (@(posedge clk_i) disable iff (rst_i)
    (outstanding >= 0) && (outstanding <= int'(PIPE_LAT) + 1));

  a_mul_gnt : assert property (@(posedge clk_i) disable iff (rst_i)
    (xfer && is_mul) |-> (pipe_empty && state == S_IDLE));

  a_busy : assert property (@(posedge clk_i) disable iff (rst_i)
    !busy_o |-> (outstanding == 0));
`else
  // No assertions in this build.
`endif

endmodule

// File: tb/tb_cv32e40p_apu_int_responder.sv
// -----------------------------------------------------------------------------
// Testbench for cv32e40p_apu_int_responder (PIPE_LAT=2).
// The stimulus tasks issue requests and push expected responses, each with its
// expected rvalid cycle, into a queue. A monitor on the falling edge pops and
// compares every rvalid pulse.
// -----------------------------------------------------------------------------
module tb_cv32e40p_apu_int_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  flags;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        apu_req_i;
  logic        apu_gnt_o;
  logic [31:0] apu_operands_i [3];
  logic [5:0]  apu_op_i;
  logic [14:0] apu_flags_i;
  logic        apu_rvalid_o;
  logic [31:0] apu_rdata_o;
  logic [4:0]  apu_rflags_o;
  logic        busy_o;

  exp_t sb [$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  cv32e40p_apu_int_responder #(
    .PIPE_LAT(LAT), .NARGS(3), .WOP(6), .NDSFLAGS(15), .NUSFLAGS(5)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .apu_req_i     (apu_req_i),
    .apu_gnt_o     (apu_gnt_o),
    .apu_operands_i(apu_operands_i),
    .apu_op_i      (apu_op_i),
    .apu_flags_i   (apu_flags_i),
    .apu_rvalid_o  (apu_rvalid_o),
    .apu_rdata_o   (apu_rdata_o),
    .apu_rflags_o  (apu_rflags_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_i && apu_rvalid_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got data 0x%08h, expected no response (cycle %0d)",
                 apu_rdata_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", apu_rdata_o, e.data);
        check("rflags", 32'(apu_rflags_o), 32'(e.flags));
        check("rvalid_cycle", cyc, e.cyc);
      end
    end
  end

  // Call just after a rising edge. The request is held until granted. The
  // number of cycles spent waiting is checked when exp_wait >= 0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic [4:0] ef, input int exp_wait);
    int   waited;
    bit   granted;
    exp_t e;
    waited  = 0;
    granted = 1'b0;
    apu_req_i         = 1'b1;
    apu_op_i          = {3'b000, op};
    apu_operands_i[0] = a;
    apu_operands_i[1] = b;
    apu_operands_i[2] = 32'hDEADBEEF;
    while (!granted && waited < 200) begin
      @(negedge clk);
      if (apu_gnt_o) begin
        granted = 1'b1;
        e.data  = ed;
        e.flags = ef;
        e.cyc   = cyc + ((op == 3'd7) ? 33 : LAT);
        sb.push_back(e);
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    apu_req_i = 1'b0;
    if (!granted) begin
      n_cmp++;
      n_fail++;
      $display("FAIL gnt_timeout: got no grant after %0d cycles, expected a grant", waited);
    end else if (exp_wait >= 0) begin
      check("gnt_wait", waited, exp_wait);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    rst_i             = 1'b1;
    apu_req_i         = 1'b0;
    apu_op_i          = '0;
    apu_flags_i       = '0;
    apu_operands_i[0] = '0;
    apu_operands_i[1] = '0;
    apu_operands_i[2] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rvalid", 32'(apu_rvalid_o), 0);
    check("reset_rdata", apu_rdata_o, 0);
    check("reset_rflags", 32'(apu_rflags_o), 0);
    check("reset_busy", 32'(busy_o), 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // ADD with unsigned wrap: zero and carry
    issue(3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b00011, 0);
    drain();

    // Back-to-back SUB / MAX / XOR
    issue(3'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 5'b00010, 0);
    issue(3'd6, 32'hFFFFFFFD, 32'd2, 32'h00000002, 5'b00000, 0);
    issue(3'd4, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 5'b00000, 0);
    drain();

    // Signed overflow
    issue(3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b00100, 0);
    issue(3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00100, 0);
    drain();

    // Remaining logic ops
    issue(3'd2, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 5'b00000, 0);
    issue(3'd3, 32'h00000000, 32'h00000000, 32'h00000000, 5'b00001, 0);
    issue(3'd5, 32'h80000000, 32'h00000001, 32'h80000000, 5'b00000, 0);
    drain();

    // MULU behind two ADDs waits 2 cycles. It is followed by an ADD that is
    // granted in the MULU RESP cycle (32 cycles of waiting), so MULU returns first.
    issue(3'd0, 32'd1, 32'd2, 32'd3, 5'b00000, 0);
    issue(3'd0, 32'h10, 32'h20, 32'h30, 5'b00000, 0);
    issue(3'd7, 32'h00010000, 32'h00010003, 32'h00030000, 5'b00000, 2);
    issue(3'd0, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 5'b00011, 32);
    drain();

    // Reset in the middle of a MULU: the result is dropped and busy clears.
    issue(3'd7, 32'd3, 32'd4, 32'd12, 5'b00000, 0);
    repeat (9) @(posedge clk);
    #1;
    check("mul_busy", 32'(busy_o), 1);
    rst_i = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midreset_busy", 32'(busy_o), 0);
    check("midreset_rvalid", 32'(apu_rvalid_o), 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(3'd0, 32'd40, 32'd2, 32'd42, 5'b00000, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
